// File: rtl/mc_cpu_core.sv
// Multicycle MIPS-subset core: req/ack memory port with wait states, byte lanes,
// and a halt state that reports illegal instructions and misaligned word accesses.
module mc_cpu_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [1:0]        fault,
  output logic [31:0]       dbg_pc,
  output logic              retire
);
  typedef enum logic [2:0] {IF_REQ, IF_WAIT, ID, EX, MEM_REQ, MEM_WAIT, WB, HALT} state_e;
  state_e state_q, state_d;

  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [4:0]  dst_q, dst_d;
  logic [31:0] rf_q [32];
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, halted_q, halted_d, retire_q, retire_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d, dbg_pc_q, dbg_pc_d;
  logic [1:0]  fault_q, fault_d;

  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic [31:0] simm_s, zimm_s, res_s, target_s, ld_data_s, rf_wdata_s;
  logic [7:0]  lane_s;
  logic [3:0]  be_s;
  logic        is_load_s, is_store_s, is_byte_s, wr_reg_s, illegal_s, taken_s;
  logic        misal_s, ack_s, rf_we_s;

  assign op_s    = ir_q[31:26];
  assign rs_s    = ir_q[25:21];
  assign rt_s    = ir_q[20:16];
  assign rd_s    = ir_q[15:11];
  assign shamt_s = ir_q[10:6];
  assign funct_s = ir_q[5:0];
  assign simm_s  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm_s  = {16'h0000, ir_q[15:0]};
  // An ack only counts while a request is actually outstanding.
  assign ack_s     = mem_ack & mem_req_q;
  assign is_byte_s = (op_s == 6'h20) || (op_s == 6'h24) || (op_s == 6'h28);
  assign misal_s   = !is_byte_s && (alu_q[1:0] != 2'b00);
  assign be_s      = is_byte_s ? (4'b0001 << alu_q[1:0]) : 4'hF;

  always_comb begin
    is_load_s = 1'b0; is_store_s = 1'b0; wr_reg_s = 1'b0; illegal_s = 1'b0;
    taken_s = 1'b0; target_s = pc_q; res_s = 32'h0000_0000;
    case (op_s)
      6'h00: begin
        wr_reg_s = 1'b1;
        case (funct_s)
          6'h00:        res_s = b_q << shamt_s;
          6'h02:        res_s = b_q >> shamt_s;
          6'h03:        res_s = $signed(b_q) >>> shamt_s;
          6'h08:        begin wr_reg_s = 1'b0; taken_s = 1'b1; target_s = a_q; end
          6'h20, 6'h21: res_s = a_q + b_q;
          6'h22, 6'h23: res_s = a_q - b_q;
          6'h24:        res_s = a_q & b_q;
          6'h25:        res_s = a_q | b_q;
          6'h26:        res_s = a_q ^ b_q;
          6'h27:        res_s = ~(a_q | b_q);
          6'h2A:        res_s = {31'd0, $signed(a_q) < $signed(b_q)};
          6'h2B:        res_s = {31'd0, a_q < b_q};
          default:      begin wr_reg_s = 1'b0; illegal_s = 1'b1; end
        endcase
      end
      6'h02:        begin taken_s = 1'b1; target_s = {pc_q[31:28], ir_q[25:0], 2'b00}; end
      6'h03: begin
        taken_s = 1'b1; target_s = {pc_q[31:28], ir_q[25:0], 2'b00};
        wr_reg_s = 1'b1; res_s = pc_q;
      end
      6'h04:        begin taken_s = (a_q == b_q); target_s = pc_q + {simm_s[29:0], 2'b00}; end
      6'h05:        begin taken_s = (a_q != b_q); target_s = pc_q + {simm_s[29:0], 2'b00}; end
      6'h08, 6'h09: begin wr_reg_s = 1'b1; res_s = a_q + simm_s; end
      6'h0A:        begin wr_reg_s = 1'b1; res_s = {31'd0, $signed(a_q) < $signed(simm_s)}; end
      6'h0B:        begin wr_reg_s = 1'b1; res_s = {31'd0, a_q < simm_s}; end
      6'h0C:        begin wr_reg_s = 1'b1; res_s = a_q & zimm_s; end
      6'h0D:        begin wr_reg_s = 1'b1; res_s = a_q | zimm_s; end
      6'h0E:        begin wr_reg_s = 1'b1; res_s = a_q ^ zimm_s; end
      6'h0F:        begin wr_reg_s = 1'b1; res_s = {ir_q[15:0], 16'h0000}; end
      6'h20, 6'h23, 6'h24: begin is_load_s = 1'b1; res_s = a_q + simm_s; end
      6'h28, 6'h2B:        begin is_store_s = 1'b1; res_s = a_q + simm_s; end
      default:      illegal_s = 1'b1;
    endcase
  end

  always_comb begin
    case (alu_q[1:0])
      2'd0:    lane_s = mdr_q[7:0];
      2'd1:    lane_s = mdr_q[15:8];
      2'd2:    lane_s = mdr_q[23:16];
      default: lane_s = mdr_q[31:24];
    endcase
    case (op_s)
      6'h20:   ld_data_s = {{24{lane_s[7]}}, lane_s};
      6'h24:   ld_data_s = {24'h000000, lane_s};
      default: ld_data_s = mdr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IF_REQ;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_REQ:   state_d = IF_WAIT;
      IF_WAIT:  if (ack_s) state_d = ID; else state_d = IF_WAIT;
      ID:       state_d = EX;
      EX: begin
        if (illegal_s && TRAP_ON_ILLEGAL)  state_d = HALT;
        else if (is_load_s || is_store_s) state_d = MEM_REQ;
        else if (wr_reg_s)                state_d = WB;
        else                              state_d = IF_REQ;
      end
      MEM_REQ:  if (misal_s) state_d = HALT; else state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (ack_s) state_d = is_load_s ? WB : IF_REQ;
        else       state_d = MEM_WAIT;
      end
      WB:       state_d = IF_REQ;
      HALT:     state_d = HALT;
      default:  state_d = HALT;
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    pc_d = pc_q; ir_d = ir_q; a_d = a_q; b_d = b_q; alu_d = alu_q; mdr_d = mdr_q; dst_d = dst_q;
    mem_req_d = mem_req_q; mem_we_d = mem_we_q; mem_be_d = mem_be_q; mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q; dbg_pc_d = dbg_pc_q; fault_d = fault_q; retire_d = 1'b0;
    rf_we_s = 1'b0; rf_wdata_s = 32'h0000_0000;
    case (state_q)
      IF_REQ: begin
        mem_req_d = 1'b1; mem_we_d = 1'b0; mem_be_d = 4'hF;
        mem_addr_d = pc_q[ADDR_W-1:0]; dbg_pc_d = pc_q;
      end
      IF_WAIT: begin
        if (ack_s) begin
          ir_d = mem_rdata; mem_req_d = 1'b0; pc_d = pc_q + 32'd4;
        end else begin
          mem_req_d = mem_req_q;
        end
      end
      ID: begin
        a_d = (rs_s == 5'd0) ? 32'h0000_0000 : rf_q[rs_s];
        b_d = (rt_s == 5'd0) ? 32'h0000_0000 : rf_q[rt_s];
        if (op_s == 6'h00)      dst_d = rd_s;
        else if (op_s == 6'h03) dst_d = 5'd31;
        else                    dst_d = rt_s;
      end
      EX: begin
        alu_d = res_s;
        if (taken_s) pc_d = target_s; else pc_d = pc_q;
        if (illegal_s && TRAP_ON_ILLEGAL) fault_d = 2'd1; else fault_d = fault_q;
        retire_d = (state_d == IF_REQ);
      end
      MEM_REQ: begin
        if (misal_s) begin
          fault_d = 2'd2; mem_req_d = 1'b0;
        end else begin
          mem_req_d = 1'b1; mem_we_d = is_store_s; mem_be_d = be_s;
          mem_addr_d = alu_q[ADDR_W-1:0];
          mem_wdata_d = is_store_s ? (is_byte_s ? {4{b_q[7:0]}} : b_q) : 32'h0000_0000;
        end
      end
      MEM_WAIT: begin
        if (ack_s) begin
          mem_req_d = 1'b0; mdr_d = mem_rdata; retire_d = is_store_s;
        end else begin
          mem_req_d = mem_req_q;
        end
      end
      WB: begin
        rf_we_s = (dst_q != 5'd0);
        rf_wdata_s = is_load_s ? ld_data_s : alu_q;
        retire_d = 1'b1;
      end
      HALT:    mem_req_d = 1'b0;
      default: mem_req_d = 1'b0;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC; ir_q <= 32'h0000_0000; a_q <= 32'h0000_0000; b_q <= 32'h0000_0000;
      alu_q <= 32'h0000_0000; mdr_q <= 32'h0000_0000; dst_q <= 5'd0;
      mem_req_q <= 1'b0; mem_we_q <= 1'b0; mem_be_q <= 4'h0; mem_addr_q <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000; dbg_pc_q <= RESET_PC; fault_q <= 2'd0;
      halted_q <= 1'b0; retire_q <= 1'b0;
    end else begin
      pc_q <= pc_d; ir_q <= ir_d; a_q <= a_d; b_q <= b_d;
      alu_q <= alu_d; mdr_q <= mdr_d; dst_q <= dst_d;
      mem_req_q <= mem_req_d; mem_we_q <= mem_we_d; mem_be_q <= mem_be_d; mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d; dbg_pc_q <= dbg_pc_d; fault_q <= fault_d;
      halted_q <= halted_d; retire_q <= retire_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0000_0000;
    end else if (rf_we_s) begin
      rf_q[dst_q] <= rf_wdata_s;
    end
  end

  assign mem_req = mem_req_q;   assign mem_we = mem_we_q;       assign mem_be = mem_be_q;
  assign mem_addr = mem_addr_q; assign mem_wdata = mem_wdata_q; assign halted = halted_q;
  assign fault = fault_q;       assign dbg_pc = dbg_pc_q;       assign retire = retire_q;
endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: small programs, a wait-state memory model and hand-computed results.
module tb_mc_cpu_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mem_req, mem_we, mem_ack, halted, retire;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_pc;
  logic [1:0]  fault;

  logic        n_req, n_we, n_ack, n_halted, n_retire;
  logic [3:0]  n_be;
  logic [15:0] n_addr;
  logic [31:0] n_wdata, n_rdata, n_dbg_pc;
  logic [1:0]  n_fault;

  mc_cpu_core #(.RESET_PC(32'h100), .ADDR_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .fault(fault), .dbg_pc(dbg_pc), .retire(retire));

  mc_cpu_core #(.RESET_PC(32'h0), .ADDR_W(16), .TRAP_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .rst(rst), .mem_req(n_req), .mem_we(n_we), .mem_be(n_be),
    .mem_addr(n_addr), .mem_wdata(n_wdata), .mem_rdata(n_rdata), .mem_ack(n_ack),
    .halted(n_halted), .fault(n_fault), .dbg_pc(n_dbg_pc), .retire(n_retire));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  // Memory model: 1 KiB, acks after wait_n extra request cycles.
  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          wcnt = 0;
  int          cyc = 0;
  int          req_starts = 0;
  bit          chk_stable = 1'b0;
  logic        prev_req = 1'b0;
  logic [39:0] lat;
  int          ret_cyc[$];
  logic [3:0]  wr_be_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] rd_log[$];

  initial begin
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (retire) ret_cyc.push_back(cyc);
      if (rst) begin
        mem_ack = 1'b0; wcnt = 0; prev_req = 1'b0;
      end else if (mem_req) begin
        if (!prev_req) begin
          req_starts++;
          lat = {mem_addr, 3'b000, mem_we, mem_be};
        end
        if (wcnt == wait_n) begin
          if (chk_stable) check("stable_while_waiting", {mem_addr, 3'b000, mem_we, mem_be}, lat);
          mem_ack = 1'b1;
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] = mem_wdata[8*i +: 8];
            wr_be_log.push_back(mem_be);
            wr_data_log.push_back(mem_wdata);
          end else begin
            mem_rdata = mem[mem_addr[9:2]];
            rd_log.push_back(mem_addr);
          end
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0; wcnt = 0;
      end
      prev_req = mem_req;
    end
  end

  // Second core sees only illegal opcodes on a zero-wait bus.
  initial begin
    n_ack = 1'b0; n_rdata = ILLEGAL;
    forever begin
      @(negedge clk);
      n_ack = n_req;
    end
  end

  task automatic hold_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    ret_cyc.delete(); wr_be_log.delete(); wr_data_log.delete(); rd_log.delete();
    req_starts = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic run_prog(input int waits);
    wait_n = waits;
    chk_stable = (waits > 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (halted) break;
    end
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic load_prog_a();
    put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF));
    put(32'h104, enc_r(5'd0, 5'd1, 5'd2, 5'd0, 6'h2B));
    put(32'h108, enc_r(5'd1, 5'd0, 5'd3, 5'd0, 6'h2A));
    put(32'h10C, enc_i(6'h08, 5'd0, 5'd8, 16'hFFF0));
    put(32'h110, enc_r(5'd0, 5'd8, 5'd9, 5'd2, 6'h03));
    put(32'h114, enc_r(5'd0, 5'd8, 5'd10, 5'd28, 6'h02));
    put(32'h118, enc_r(5'd10, 5'd8, 5'd11, 5'd0, 6'h22));
    put(32'h11C, enc_r(5'd11, 5'd0, 5'd12, 5'd0, 6'h27));
    put(32'h120, enc_i(6'h05, 5'd11, 5'd0, 16'h0001));
    put(32'h124, enc_i(6'h08, 5'd0, 5'd11, 16'h0000));
    put(32'h128, enc_i(6'h2B, 5'd0, 5'd1, 16'h0300));
    put(32'h12C, enc_i(6'h2B, 5'd0, 5'd2, 16'h0304));
    put(32'h130, enc_i(6'h2B, 5'd0, 5'd3, 16'h0308));
    put(32'h134, enc_i(6'h2B, 5'd0, 5'd9, 16'h030C));
    put(32'h138, enc_i(6'h2B, 5'd0, 5'd10, 16'h0310));
    put(32'h13C, enc_i(6'h2B, 5'd0, 5'd11, 16'h0314));
    put(32'h140, enc_i(6'h2B, 5'd0, 5'd12, 16'h0318));
    put(32'h144, ILLEGAL);
  endtask

  task automatic check_prog_a(input int w);
    check("a_addi_m1",  mem[32'h300 >> 2], 32'hFFFF_FFFF);
    check("a_sltu",     mem[32'h304 >> 2], 32'h1);
    check("a_slt",      mem[32'h308 >> 2], 32'h1);
    check("a_sra",      mem[32'h30C >> 2], 32'hFFFF_FFFC);
    check("a_srl",      mem[32'h310 >> 2], 32'h0000_000F);
    check("a_sub_bne",  mem[32'h314 >> 2], 32'h0000_001F);
    check("a_nor",      mem[32'h318 >> 2], 32'hFFFF_FFE0);
    check("a_gap_alu1", ret_cyc[1] - ret_cyc[0], 5 + w);
    check("a_gap_alu2", ret_cyc[2] - ret_cyc[1], 5 + w);
    check("a_gap_br",   ret_cyc[8] - ret_cyc[7], 4 + w);
    check("a_gap_sw",   ret_cyc[9] - ret_cyc[8], 6 + 2 * w);
    check("a_fault",    fault, 2'd1);
    check("a_pc",       dbg_pc, 32'h144);
  endtask

  int   nf;
  logic pr;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk); #1;
    check("rst_req",    mem_req, 1'b0);
    check("rst_addr",   mem_addr, 32'h0);
    check("rst_be",     mem_be, 4'h0);
    check("rst_dbg_pc", dbg_pc, 32'h100);
    check("rst_halted", halted, 1'b0);
    check("rst_fault",  fault, 2'd0);
    check("rst_retire", retire, 1'b0);

    wait_n = 3;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("first_req",  mem_req, 1'b1);
    check("first_addr", mem_addr, 32'h100);
    @(posedge clk); #1;
    check("still_req",  mem_req, 1'b1);
    rst = 1'b1; #1;
    check("rst_drops_req", mem_req, 1'b0);

    @(negedge clk) rst = 1'b0;
    nf = 0; pr = 1'b0;
    for (int i = 0; i < 60 && nf < 4; i++) begin
      @(posedge clk); #1;
      if (n_req && !pr) nf++;
      pr = n_req;
    end
    check("nop_fetches", nf, 4);
    check("nop_pc",      n_dbg_pc, 32'h0000_000C);
    check("nop_halted",  n_halted, 1'b0);
    check("nop_fault",   n_fault, 2'd0);

    hold_reset(); load_prog_a(); run_prog(0); check_prog_a(0);
    hold_reset(); load_prog_a(); run_prog(3); check_prog_a(3);

    hold_reset();
    put(32'h100, enc_i(6'h0F, 5'd0, 5'd5, 16'h1234));
    put(32'h104, enc_i(6'h0D, 5'd5, 5'd5, 16'h56AB));
    put(32'h108, enc_i(6'h28, 5'd0, 5'd5, 16'h0203));
    put(32'h10C, enc_i(6'h20, 5'd0, 5'd6, 16'h0203));
    put(32'h110, enc_i(6'h24, 5'd0, 5'd7, 16'h0203));
    put(32'h114, enc_i(6'h2B, 5'd0, 5'd6, 16'h0300));
    put(32'h118, enc_i(6'h2B, 5'd0, 5'd7, 16'h0304));
    put(32'h11C, ILLEGAL);
    run_prog(0);
    check("sb_be",      wr_be_log[0], 4'b1000);
    check("sb_wdata",   wr_data_log[0], 32'hABAB_ABAB);
    check("sb_mem",     mem[32'h200 >> 2], 32'hAB00_0000);
    check("lb_sext",    mem[32'h300 >> 2], 32'hFFFF_FFAB);
    check("lbu_zext",   mem[32'h304 >> 2], 32'h0000_00AB);
    check("gap_ori",    ret_cyc[1] - ret_cyc[0], 5);
    check("gap_sb",     ret_cyc[2] - ret_cyc[1], 6);
    check("gap_lb",     ret_cyc[3] - ret_cyc[2], 7);

    hold_reset();
    put(32'h100, enc_j(6'h02, 26'h4));
    put(32'h010, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFC));
    put(32'h014, ILLEGAL);
    put(32'h004, enc_j(6'h02, 26'h8));
    put(32'h020, enc_j(6'h03, 26'h10));
    put(32'h024, ILLEGAL);
    put(32'h040, enc_i(6'h2B, 5'd0, 5'd31, 16'h0300));
    put(32'h044, ILLEGAL);
    run_prog(0);
    check("fetch_j",    rd_log[1], 32'h10);
    check("fetch_beq",  rd_log[2], 32'h04);
    check("fetch_jal",  rd_log[4], 32'h40);
    check("jal_ra",     mem[32'h300 >> 2], 32'h24);
    check("jmp_end_pc", dbg_pc, 32'h44);
    check("gap_beq",    ret_cyc[1] - ret_cyc[0], 4);
    check("gap_jal",    ret_cyc[3] - ret_cyc[2], 5);

    hold_reset();
    put(32'h100, enc_i(6'h23, 5'd0, 5'd1, 16'h0202));
    run_prog(0);
    check("misal_fault", fault, 2'd2);
    check("misal_reqs",  req_starts, 1);
    check("misal_req",   mem_req, 1'b0);
    check("misal_pc",    dbg_pc, 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
